// File: rtl/writeback_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_queue_pkg
//  Description : Shared processor constants for the register file and the
//                write-back queue, plus a small pointer-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package writeback_queue_pkg;

    // Data word width shared with the register file
    localparam int c_WORD_LEN     = 32;
    // Register index width (2^14-entry register file)
    localparam int c_REG_ADDR_LEN = 14;
    // Write-back queue entries (power of two, at least 2)
    localparam int c_DEPTH        = 4;

    // Width of a pointer that indexes a queue of the given depth
    function automatic int wb_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_queue_if
//  Description : Producer, register-file write port and bypass lookup bundle
//                for the write-back queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface writeback_queue_if
    import writeback_queue_pkg::*;
#(
    parameter int WordLen    = c_WORD_LEN,
    parameter int RegAddrLen = c_REG_ADDR_LEN
);
    // Producer side
    logic                  inValid;
    logic                  inReady;
    logic [RegAddrLen-1:0] inReg;
    logic [WordLen-1:0]    inData;
    // Register-file write port
    logic                  wbEnable;
    logic                  regWrite;
    logic [RegAddrLen-1:0] writeRegister;
    logic [WordLen-1:0]    writeData;
    // Bypass lookups
    logic [RegAddrLen-1:0] lookupReg1;
    logic [RegAddrLen-1:0] lookupReg2;
    logic                  hit1;
    logic                  hit2;
    logic [WordLen-1:0]    hitData1;
    logic [WordLen-1:0]    hitData2;
    // Occupancy
    logic                  empty;
    logic                  full;

    modport master (
        output inValid, inReg, inData, wbEnable, lookupReg1, lookupReg2,
        input  inReady, regWrite, writeRegister, writeData,
        input  hit1, hit2, hitData1, hitData2, empty, full
    );

    modport slave (
        input  inValid, inReg, inData, wbEnable, lookupReg1, lookupReg2,
        output inReady, regWrite, writeRegister, writeData,
        output hit1, hit2, hitData1, hitData2, empty, full
    );

endinterface
`default_nettype wire

// File: rtl/writeback_queue_bypass_match.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_match
//  Description : Youngest-match search over the occupied queue entries for
//                one bypass lookup port.
//  Revision    : 1.0 - initial release
// ============================================================================
module bypass_match
    import writeback_queue_pkg::*;
#(
    parameter int WordLen    = c_WORD_LEN,
    parameter int RegAddrLen = c_REG_ADDR_LEN,
    parameter int Depth      = c_DEPTH
) (
    input  logic [Depth-1:0][RegAddrLen-1:0] i_regs,
    input  logic [Depth-1:0][WordLen-1:0]    i_datas,
    input  logic [wb_ptr_width(Depth)-1:0]   i_head,
    input  logic [$clog2(Depth+1)-1:0]       i_count,
    input  logic [RegAddrLen-1:0]            i_lookup,
    output logic                             o_hit,
    output logic [WordLen-1:0]               o_data
);

    localparam int c_PTR_W = wb_ptr_width(Depth);
    localparam int c_CNT_W = $clog2(Depth + 1);

    logic [c_PTR_W-1:0] w_idx;

    // Walk entries oldest to youngest; a later match overrides an earlier one,
    // so the final value belongs to the youngest matching entry. Register 0
    // is never stored and never reported as a hit.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < Depth; i++) begin
            w_idx = i_head + c_PTR_W'(i);
            if ((c_CNT_W'(i) < i_count) && (i_lookup != '0) &&
                (i_regs[w_idx] == i_lookup)) begin
                o_hit  = 1'b1;
                o_data = i_datas[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_queue
//  Description : In-order write-back FIFO in front of a single register-file
//                write port, with two youngest-match bypass lookup ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int WordLen    = c_WORD_LEN,
    parameter int RegAddrLen = c_REG_ADDR_LEN,
    parameter int Depth      = c_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    writeback_queue_if.slave       wb
);

    localparam int                 c_PTR_W      = wb_ptr_width(Depth);
    localparam int                 c_CNT_W      = $clog2(Depth + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(Depth);

    // Pointers and occupancy are the only reset state; storage is gated by count
    logic [c_PTR_W-1:0]               r_head;
    logic [c_PTR_W-1:0]               r_tail;
    logic [c_CNT_W-1:0]               r_count;
    logic [Depth-1:0][RegAddrLen-1:0] r_regs;
    logic [Depth-1:0][WordLen-1:0]    r_datas;

    logic w_empty;
    logic w_full;
    logic w_accept;
    logic w_store;
    logic w_drain;

    // Handshake decode: full is based on the current count only, so a drain
    // in the same cycle never frees a slot for an incoming write. A write to
    // register 0 completes the handshake but is dropped.
    always_comb begin
        w_empty  = (r_count == '0);
        w_full   = (r_count == c_FULL_COUNT);
        w_accept = wb.inValid && !w_full;
        w_store  = w_accept && (wb.inReg != '0);
        w_drain  = !w_empty && wb.wbEnable;
    end

    // Head/tail pointers wrap naturally because Depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_store, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are meaningful only inside the occupied window
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_regs[r_tail]  <= wb.inReg;
            r_datas[r_tail] <= wb.inData;
        end
    end

    // Head presentation and flags; everything comes from registered state,
    // so an accepted entry is visible only after the accepting edge.
    always_comb begin
        wb.inReady       = !w_full;
        wb.empty         = w_empty;
        wb.full          = w_full;
        wb.regWrite      = w_drain;
        wb.writeRegister = w_empty ? '0 : r_regs[r_head];
        wb.writeData     = w_empty ? '0 : r_datas[r_head];
    end

    bypass_match #(
        .WordLen    (WordLen),
        .RegAddrLen (RegAddrLen),
        .Depth      (Depth)
    ) u_bypass1 (
        .i_regs   (r_regs),
        .i_datas  (r_datas),
        .i_head   (r_head),
        .i_count  (r_count),
        .i_lookup (wb.lookupReg1),
        .o_hit    (wb.hit1),
        .o_data   (wb.hitData1)
    );

    bypass_match #(
        .WordLen    (WordLen),
        .RegAddrLen (RegAddrLen),
        .Depth      (Depth)
    ) u_bypass2 (
        .i_regs   (r_regs),
        .i_datas  (r_datas),
        .i_head   (r_head),
        .i_count  (r_count),
        .i_lookup (wb.lookupReg2),
        .o_hit    (wb.hit2),
        .o_data   (wb.hitData2)
    );

endmodule
`default_nettype wire

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter WordLen, default 32, data word width.
REQ-002 SHALL have parameter RegAddrLen, default 14, register index width (2^14-entry register file).
REQ-003 SHALL have parameter Depth, default 4, queue entries (power of two, at least 2).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 inValid  input  1  producer offers a write-back.
REQ-007 inReady  output  1  queue can accept this cycle.
REQ-008 inReg  input  RegAddrLen  destination register of offered write.
REQ-009 inData  input  WordLen  data of offered write.
REQ-010 wbEnable  input  1  register-file write port is free this cycle.
REQ-011 regWrite  output  1  write strobe to register file.
REQ-012 writeRegister  output  RegAddrLen  head-entry register index.
REQ-013 writeData  output  WordLen  head-entry data.
REQ-014 lookupReg1, lookupReg2  input  RegAddrLen each  bypass query indices.
REQ-015 hit1, hit2  output  1 each  a pending write matches the query.
REQ-016 hitData1, hitData2  output  WordLen each  data of the youngest matching entry.
REQ-017 empty, full  output  1 each  occupancy flags.

Function
REQ-018 SHALL be a FIFO of Depth {reg, data} entries; count 0..Depth.
REQ-019 inReady SHALL equal !full; full asserts when count == Depth, based on current count only (no same-cycle drain credit).
REQ-020 Accept SHALL occur on a rising edge with inValid && inReady; entry appended at tail.
REQ-021 An offered write with inReg == 0 SHALL be accepted (handshake completes) but not stored; count unchanged.
REQ-022 regWrite SHALL equal !empty && wbEnable, combinationally; writeRegister/writeData SHALL show the head entry whenever !empty, and 0 when empty.
REQ-023 Drain SHALL occur on a rising edge with regWrite high; head removed.
REQ-024 Minimum latency: entry accepted at edge N SHALL be presented on regWrite no earlier than the cycle after edge N (no combinational in-to-out path).
REQ-025 Simultaneous accept and drain SHALL leave count unchanged and preserve order; at full, accept is refused even if a drain occurs in the same cycle.
REQ-026 Head/tail pointers SHALL wrap modulo Depth.
REQ-027 hitN SHALL be high when any stored entry has reg == lookupRegN and lookupRegN != 0; hitDataN SHALL be the data of the youngest such entry, else 0.
REQ-028 Bypass SHALL consider stored entries only, including the head being drained this cycle, and SHALL exclude the same-cycle incoming write.
REQ-029 Multiple pending writes to one register SHALL all be drained in order (no coalescing).

Reset
REQ-030 rst_n low SHALL immediately clear count and pointers: empty=1, full=0, inReady=1, regWrite=0, hit1/hit2=0, all data outputs 0.
REQ-031 Reset mid-operation SHALL discard all pending entries; the first accept after release SHALL occur on the first rising edge with rst_n high.
REQ-032 Entry storage contents need not be reset; valid tracking alone SHALL gate all outputs.

Structure
REQ-033 Parameter defaults (WordLen, RegAddrLen, Depth) SHALL live in the shared processor package for use by the register file and this block.
REQ-034 Youngest-match bypass search SHALL be a sub-module, bypass_match, instantiated once per lookup port.

Verification
REQ-035 Reset, then push (reg 5, 0xAAAA0001) with wbEnable=0 -> empty=0, hit1=1 for lookupReg1=5 with hitData1=0xAAAA0001, regWrite=0.
REQ-036 Push 4 entries with wbEnable=0 -> full=1, inReady=0; 5th offer not accepted; raise wbEnable -> 4 writes in push order, one per cycle.
REQ-037 Push (reg 7, 1) then (reg 7, 2), lookupReg2=7 -> hitData2=2; after first drain still 2; after second drain hit2=0.
REQ-038 Offer (reg 0, 0xFFFF) -> accepted, empty stays 1, regWrite never asserts, lookup of 0 gives hit=0.
REQ-039 Full queue, wbEnable=1, inValid=1 same cycle -> one drain, no accept, count becomes 3; next cycle accept succeeds; pointers wrap correctly over 10 push/drain cycles.
REQ-040 Three entries pending, pulse rst_n low between edges -> empty=1 and regWrite=0 asynchronously; no stale write appears after release.
